// File: rtl/reset_autoplay_seq_if.sv
// Control, configuration and status bundle for reset_autoplay_seq.
// master drives lock/button/autoplay config; slave is the sequencer.
interface reset_autoplay_seq_if #(
  parameter int unsigned NCHAN = 3,
  parameter int unsigned AW    = 32
);
  logic                  dcm_locked;
  logic                  button;
  logic                  auto_en;
  logic [NCHAN*AW-1:0]   chan_start;
  logic [NCHAN*AW-1:0]   chan_len;
  logic [NCHAN*AW-1:0]   chan_period;
  logic                  sys_reset;
  logic                  button_db;
  logic [NCHAN-1:0]      auto_n;

  modport master (
    output dcm_locked, button, auto_en, chan_start, chan_len, chan_period,
    input  sys_reset, button_db, auto_n
  );

  modport slave (
    input  dcm_locked, button, auto_en, chan_start, chan_len, chan_period,
    output sys_reset, button_db, auto_n
  );
endinterface

// File: rtl/reset_autoplay_seq.sv
// Power-on/button reset sequencer with debounced button and N-channel autoplay.
// Define AUTOPLAY_EN to build the autoplay timebase/channels; otherwise auto_n is all ones.
module reset_autoplay_seq #(
  parameter int unsigned RST_HOLD = 8191,
  parameter int unsigned RST_W    = 16,
  parameter int unsigned DEB_W    = 16,
  parameter int unsigned NCHAN    = 3,
  parameter int unsigned AW       = 32
) (
  input  logic               sysclk,
  input  logic               reset_n,
  reset_autoplay_seq_if.slave bus
);

  typedef enum logic {ST_RESET, ST_RUN} state_t;

  localparam logic [RST_W-1:0] HOLD_LAST = RST_W'(RST_HOLD - 1);
  // Debounce fires on the edge whose increment would reach 2^DEB_W-1.
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'((64'd1 << DEB_W) - 64'd2);

  logic             sync1_q, sync2_q;
  logic             button_db_q;
  logic [DEB_W-1:0] deb_cnt_q;
  state_t           state_q;
  logic [RST_W-1:0] hold_q;
  logic             sys_reset_q;
  logic             qual;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      button_db_q <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      sync1_q <= bus.button;
      sync2_q <= sync1_q;
      if (sync2_q != button_db_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          button_db_q <= sync2_q;
          deb_cnt_q   <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign qual = bus.dcm_locked & ~button_db_q;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      hold_q      <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (!qual) begin
            hold_q <= '0;
          end else if (hold_q == HOLD_LAST) begin
            state_q     <= ST_RUN;
            hold_q      <= '0;
            sys_reset_q <= 1'b0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!qual) begin
            state_q     <= ST_RESET;
            hold_q      <= '0;
            sys_reset_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_RESET;
          hold_q      <= '0;
          sys_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sys_reset = sys_reset_q;
  assign bus.button_db = button_db_q;

`ifdef AUTOPLAY_EN
  logic                       ap_clr;
  logic [AW-1:0]              a_count_q, a_count_d;
  logic [NCHAN-1:0]           started_q;
  logic [NCHAN-1:0][AW-1:0]   p_q;
  logic [NCHAN-1:0]           active;
  logic [NCHAN-1:0]           auto_n_q;

  assign ap_clr = sys_reset_q | ~bus.auto_en;

  always_comb begin
    a_count_d = a_count_q;
    if (ap_clr) begin
      a_count_d = '0;
    end else if (a_count_q != '1) begin
      a_count_d = a_count_q + 1'b1;
    end
  end

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      active[i] = started_q[i] & (p_q[i] < bus.chan_len[i*AW +: AW]);
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      a_count_q <= '0;
    end else begin
      a_count_q <= a_count_d;
    end
  end

  // Start is latched once, so a start at the saturated timebase value fires a single time.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      started_q <= '0;
      p_q       <= '0;
      auto_n_q  <= '1;
    end else if (ap_clr) begin
      started_q <= '0;
      p_q       <= '0;
      auto_n_q  <= '1;
    end else begin
      auto_n_q <= ~active;
      for (int unsigned i = 0; i < NCHAN; i++) begin
        if (!started_q[i]) begin
          if (a_count_q == bus.chan_start[i*AW +: AW]) begin
            started_q[i] <= 1'b1;
            p_q[i]       <= '0;
          end
        end else if (bus.chan_period[i*AW +: AW] != '0) begin
          if (p_q[i] >= bus.chan_period[i*AW +: AW] - 1'b1) begin
            p_q[i] <= '0;
          end else begin
            p_q[i] <= p_q[i] + 1'b1;
          end
        end else if (p_q[i] != '1) begin
          p_q[i] <= p_q[i] + 1'b1;
        end
      end
    end
  end

  assign bus.auto_n = auto_n_q;
`else
  logic [3*NCHAN*AW:0] unused_cfg;

  assign unused_cfg = {bus.auto_en, bus.chan_start, bus.chan_len, bus.chan_period};
  assign bus.auto_n = {NCHAN{1'b1}};
`endif

endmodule
